// File: rtl/b06_pkg.sv
// Shared types and default sizing for the b06 EQL source block.
package b06_pkg;

  // Compare FSM: IDLE accepts a word, HOLD keeps the result until the FSM acknowledges it.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_DATA_W     = 4;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_TERM_COUNT = 10;
  localparam int DEF_TIMEOUT    = 16;

  // Width needed to hold the values 0..max.
  function automatic int cnt_bits(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/b06_term_counter.sv
// Terminal counter: counts while enabled, saturates at TERM_COUNT and flags arrival there.
module b06_term_counter
  import b06_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TERM_COUNT = DEF_TERM_COUNT
) (
  input  logic clock,
  input  logic nRESET_G,
  input  logic enable_count,
  output logic cont_eql
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERM_COUNT);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Saturating increment; the flag is computed from the same next value that is stored.
  assign count_nxt = (count == TERM) ? count : count + 1'b1;

  // Count while enabled; any disabled cycle restarts from zero so there is no carry-over.
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      count    <= '0;
      cont_eql <= 1'b0;
    end else if (!enable_count) begin
      count    <= '0;
      cont_eql <= 1'b0;
    end else begin
      count    <= count_nxt;
      cont_eql <= (count_nxt == TERM);
    end
  end

endmodule

// File: rtl/b06_eql_source.sv
// Upstream stage of the b06 interrupt handler: produces EQL (held compare against a
// loadable reference) and CONT_EQL (terminal counter flag).
// Optional feature macro: B06_EQL_TIMEOUT_EN -- abandons a held compare if the
// acknowledge does not arrive within TIMEOUT cycles and pulses ERR.
module b06_eql_source
  import b06_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TERM_COUNT = DEF_TERM_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              nRESET_G,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
  input  logic [DATA_W-1:0] REF_IN,
  input  logic              REF_LOAD,
  input  logic              ENABLE_COUNT,
  input  logic              ACKOUT,
  output logic              EQL,
  output logic              CONT_EQL,
  output logic              BUSY,
  output logic              ERR
);

  state_t            state;
  logic [DATA_W-1:0] ref_q;
  logic              eql_q;
  logic              busy_q;

  assign EQL  = eql_q;
  assign BUSY = busy_q;

  // Reference register; a compare in the same cycle as a load still sees the old value.
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      ref_q <= '0;
    end else if (REF_LOAD) begin
      ref_q <= REF_IN;
    end
  end

`ifdef B06_EQL_TIMEOUT_EN
  localparam int WAIT_W = cnt_bits(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  assign ERR = err_q;

  // Compare FSM with ACK timeout: wait_cnt counts completed HOLD cycles without ACKOUT.
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state    <= IDLE;
      eql_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (DATA_VALID) begin
            eql_q  <= (DATA_IN == ref_q);
            busy_q <= 1'b1;
            state  <= HOLD;
          end else begin
            eql_q <= 1'b0;
          end
        end
        HOLD: begin
          if (ACKOUT) begin
            eql_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q  <= 1'b1;
            eql_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign ERR = 1'b0;

  // Compare FSM: HOLD keeps EQL/BUSY until ACKOUT, however long that takes.
  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state  <= IDLE;
      eql_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            eql_q  <= (DATA_IN == ref_q);
            busy_q <= 1'b1;
            state  <= HOLD;
          end else begin
            eql_q <= 1'b0;
          end
        end
        HOLD: begin
          if (ACKOUT) begin
            eql_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  b06_term_counter #(
    .CNT_W     (CNT_W),
    .TERM_COUNT(TERM_COUNT)
  ) u_term_counter (
    .clock       (clock),
    .nRESET_G    (nRESET_G),
    .enable_count(ENABLE_COUNT),
    .cont_eql    (CONT_EQL)
  );

endmodule

// File: tb/tb_b06_eql_source.sv
// Directed bench for b06_eql_source (default parameters: DATA_W=4, TERM_COUNT=10, TIMEOUT=16).
module tb_b06_eql_source;

  logic       clock;
  logic       nRESET_G;
  logic [3:0] DATA_IN;
  logic       DATA_VALID;
  logic [3:0] REF_IN;
  logic       REF_LOAD;
  logic       ENABLE_COUNT;
  logic       ACKOUT;
  logic       EQL;
  logic       CONT_EQL;
  logic       BUSY;
  logic       ERR;

  int vectors = 0;
  int miscompares = 0;

  b06_eql_source dut (
    .clock       (clock),
    .nRESET_G    (nRESET_G),
    .DATA_IN     (DATA_IN),
    .DATA_VALID  (DATA_VALID),
    .REF_IN      (REF_IN),
    .REF_LOAD    (REF_LOAD),
    .ENABLE_COUNT(ENABLE_COUNT),
    .ACKOUT      (ACKOUT),
    .EQL         (EQL),
    .CONT_EQL    (CONT_EQL),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    nRESET_G     = 1'b0;
    DATA_IN      = 4'h0;
    DATA_VALID   = 1'b0;
    REF_IN       = 4'h0;
    REF_LOAD     = 1'b0;
    ENABLE_COUNT = 1'b0;
    ACKOUT       = 1'b0;
    #12;
    chk("rst_eql", EQL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cont", CONT_EQL, 0);
    chk("rst_err", ERR, 0);
    nRESET_G = 1'b1;
    tick();

    // Compare handshake
    REF_LOAD = 1'b1; REF_IN = 4'h9;
    tick();
    REF_LOAD = 1'b0; DATA_VALID = 1'b1; DATA_IN = 4'h9;
    tick();
    chk("hs_eql", EQL, 1);
    chk("hs_busy", BUSY, 1);
    DATA_IN = 4'h3;
    tick();
    chk("hs_ignore_eql", EQL, 1);
    chk("hs_ignore_busy", BUSY, 1);
    DATA_VALID = 1'b0; ACKOUT = 1'b1;
    tick();
    chk("hs_ack_eql", EQL, 0);
    chk("hs_ack_busy", BUSY, 0);
    // ACKOUT in IDLE has no effect; a valid word is still accepted
    DATA_VALID = 1'b1; DATA_IN = 4'h9;
    tick();
    chk("idle_ack_eql", EQL, 1);
    chk("idle_ack_busy", BUSY, 1);
    // Valid word on the ACK cycle is dropped
    tick();
    chk("ackcyc_eql", EQL, 0);
    chk("ackcyc_busy", BUSY, 0);
    ACKOUT = 1'b0; DATA_VALID = 1'b0;
    tick();

    // Same-cycle load uses old reference
    REF_LOAD = 1'b1; REF_IN = 4'h5; DATA_VALID = 1'b1; DATA_IN = 4'h5;
    tick();
    chk("samecyc_eql", EQL, 0);
    chk("samecyc_busy", BUSY, 1);
    REF_LOAD = 1'b0; DATA_VALID = 1'b0; ACKOUT = 1'b1;
    tick();
    ACKOUT = 1'b0; DATA_VALID = 1'b1; DATA_IN = 4'h5;
    tick();
    chk("newref_eql", EQL, 1);
    // Load during HOLD does not re-evaluate
    DATA_VALID = 1'b0; REF_LOAD = 1'b1; REF_IN = 4'h7;
    tick();
    chk("holdload_eql", EQL, 1);
    REF_LOAD = 1'b0; ACKOUT = 1'b1;
    tick();
    ACKOUT = 1'b0;
    // IDLE without a valid word keeps EQL low
    DATA_IN = 4'h7;
    tick();
    chk("idle_novalid_eql", EQL, 0);

    // Counter: 12 enabled edges
    ENABLE_COUNT = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("cnt_edge%0d", i), CONT_EQL, (i >= 10) ? 1 : 0);
    end
    ENABLE_COUNT = 1'b0;
    tick();
    chk("cnt_drop", CONT_EQL, 0);

    // Counter restart: no carry-over after a disabled cycle
    ENABLE_COUNT = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ENABLE_COUNT = 1'b0;
    tick();
    ENABLE_COUNT = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 4) chk($sformatf("restart_edge%0d", i), CONT_EQL, (i == 10) ? 1 : 0);
    end

    // Reset mid-HOLD with EQL=1 and CONT_EQL=1 (ref currently 4'h7)
    DATA_VALID = 1'b1; DATA_IN = 4'h7;
    tick();
    chk("prerst_eql", EQL, 1);
    chk("prerst_cont", CONT_EQL, 1);
    DATA_VALID = 1'b0;
    #2 nRESET_G = 1'b0;
    #1;
    chk("async_rst_eql", EQL, 0);
    chk("async_rst_busy", BUSY, 0);
    chk("async_rst_cont", CONT_EQL, 0);
    chk("async_rst_err", ERR, 0);
    ENABLE_COUNT = 1'b0;
    tick();
    nRESET_G = 1'b1;
    // IDLE after reset, ref cleared: 0 compares equal with no ACK needed first
    DATA_VALID = 1'b1; DATA_IN = 4'h0;
    tick();
    chk("postrst_eql", EQL, 1);
    chk("postrst_busy", BUSY, 1);
    DATA_VALID = 1'b0;

`ifdef B06_EQL_TIMEOUT_EN
    // Timeout: no ACK for 16 HOLD cycles
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) begin
        chk("to_pre_err", ERR, 0);
        chk("to_pre_busy", BUSY, 1);
      end
    end
    tick();
    chk("to_err", ERR, 1);
    chk("to_eql", EQL, 0);
    chk("to_busy", BUSY, 0);
    tick();
    chk("to_err_pulse", ERR, 0);
    // ACK exactly on the 16th HOLD cycle wins
    DATA_VALID = 1'b1; DATA_IN = 4'h0;
    tick();
    DATA_VALID = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    ACKOUT = 1'b1;
    tick();
    chk("to_ack_err", ERR, 0);
    chk("to_ack_busy", BUSY, 0);
    ACKOUT = 1'b0;
    tick();
    chk("to_ack_err_after", ERR, 0);
`else
    // Without the timeout option HOLD persists indefinitely
    for (int i = 0; i < 20; i++) tick();
    chk("nto_busy", BUSY, 1);
    chk("nto_eql", EQL, 1);
    chk("nto_err", ERR, 0);
    ACKOUT = 1'b1;
    tick();
    chk("nto_ack_busy", BUSY, 0);
    ACKOUT = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
